// File: rtl/audioport_pkg.sv
// ============================================================================
// audioport_pkg : scheduler state encoding and status bit positions
// Rev 1.0
// ============================================================================
`default_nettype none

package audioport_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_REQ = 3'd1,
    S_FETCH    = 3'd2,
    S_START    = 3'd3,
    S_PROCESS  = 3'd4,
    S_DONE     = 3'd5
  } sched_state_t;

  localparam int STATUS_UNDERRUN = 0;
  localparam int STATUS_REQMISS  = 1;
  localparam int STATUS_TIMEOUT  = 2;

endpackage

`default_nettype wire

// File: rtl/audio_scheduler.sv
// ============================================================================
// audio_scheduler : sequences FIFO pop -> DSP start -> result valid per request,
// with sticky error flags and refill irq. Optional DSP watchdog: SCHED_WATCHDOG_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module audio_scheduler
  import audioport_pkg::*;
#(
  parameter int FIFO_AW    = 4,
  parameter int IRQ_THRESH = 4
`ifdef SCHED_WATCHDOG_EN
  , parameter int DSP_TIMEOUT = 64
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               play_in,
  input  logic               req_in,
  input  logic               fifo_empty_in,
  input  logic [FIFO_AW:0]   fifo_level_in,
  output logic               fifo_rd_out,
  output logic               dsp_start_out,
  output logic               dsp_mute_out,
  input  logic               dsp_done_in,
  output logic               out_valid_out,
  output logic               irq_out,
  input  logic               irq_ack_in,
  output logic [2:0]         status_out,
  input  logic               status_clr_in
);

  localparam logic [FIFO_AW:0] C_IRQ_THRESH = IRQ_THRESH[FIFO_AW:0];

  sched_state_t state_q, state_d;
  logic         mute_q, mute_d;
  logic [2:0]   status_q, status_d;
  logic [2:0]   w_status_set;
  logic         irq_q, irq_d;
  logic         armed_q, armed_d;
  logic         w_level_low;
  logic         w_wd_fire;
  logic         w_busy;

`ifdef SCHED_WATCHDOG_EN
  localparam logic [7:0] C_WD_LAST = 8'(DSP_TIMEOUT - 1);
  logic [7:0] wd_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != S_PROCESS) wd_cnt_q <= 8'd0;
    else                             wd_cnt_q <= wd_cnt_q + 8'd1;
  end

  assign w_wd_fire = (state_q == S_PROCESS) && !dsp_done_in && (wd_cnt_q == C_WD_LAST);
`else
  assign w_wd_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mute_q   <= 1'b0;
      status_q <= 3'b000;
      irq_q    <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      mute_q   <= mute_d;
      status_q <= status_d;
      irq_q    <= irq_d;
      armed_q  <= armed_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mute_d        = mute_q;
    fifo_rd_out   = 1'b0;
    dsp_start_out = 1'b0;
    dsp_mute_out  = 1'b0;
    out_valid_out = 1'b0;
    unique case (state_q)
      S_IDLE: if (play_in) state_d = S_WAIT_REQ;
      S_WAIT_REQ: begin
        if (!play_in) begin
          state_d = S_IDLE;
        end else if (req_in) begin
          state_d = fifo_empty_in ? S_START : S_FETCH;
          mute_d  = fifo_empty_in;
        end
      end
      S_FETCH: begin
        fifo_rd_out = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        dsp_start_out = 1'b1;
        dsp_mute_out  = mute_q;
        state_d       = S_PROCESS;
      end
      S_PROCESS: begin
        if (dsp_done_in)    state_d = S_DONE;
        else if (w_wd_fire) state_d = play_in ? S_WAIT_REQ : S_IDLE;
      end
      S_DONE: begin
        out_valid_out = 1'b1;
        state_d       = play_in ? S_WAIT_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A request arriving while a sample is in flight cannot be queued, only reported.
  assign w_busy = (state_q == S_FETCH) || (state_q == S_START) ||
                  (state_q == S_PROCESS) || (state_q == S_DONE);

  always_comb begin
    w_status_set                  = 3'b000;
    w_status_set[STATUS_UNDERRUN] = (state_q == S_WAIT_REQ) && play_in && req_in && fifo_empty_in;
    w_status_set[STATUS_REQMISS]  = w_busy && req_in;
    w_status_set[STATUS_TIMEOUT]  = w_wd_fire;
    status_d = (status_clr_in ? 3'b000 : status_q) | w_status_set;
  end

  assign w_level_low = (fifo_level_in <= C_IRQ_THRESH);

  // Ack is applied after the set so a coincident ack wins and leaves irq disarmed.
  always_comb begin
    irq_d   = irq_q;
    armed_d = armed_q;
    if (!w_level_low) armed_d = 1'b1;
    if (play_in && armed_q && w_level_low) begin
      irq_d   = 1'b1;
      armed_d = 1'b0;
    end
    if (irq_ack_in) irq_d = 1'b0;
    if (!play_in)   irq_d = 1'b0;
  end

  assign irq_out    = irq_q;
  assign status_out = status_q;

endmodule

`default_nettype wire
